// File: rtl/regfile_wb_queue_pkg.sv
// Shared types for the register-file write-back queue (optional forwarding: WB_FORWARD_EN).
// Entry layout {rd, data}; producers are ALU and load unit.
package regfile_wb_queue_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  typedef struct packed {
    logic [AW_DEF-1:0] rd;
    logic [DW_DEF-1:0] data;
  } wb_entry_t;

  typedef enum logic {SRC_ALU = 1'b0, SRC_LD = 1'b1} src_t;

  function automatic src_t src_other(input src_t s);
    return (s == SRC_ALU) ? SRC_LD : SRC_ALU;
  endfunction

endpackage

// File: rtl/regfile_wb_queue_fifo.sv
// In-order FIFO that also exposes every entry oldest-first for the forwarding CAM.
// Push visible at head the cycle after the edge; caller must not push when full or pop when empty.
module wb_fifo #(
  parameter  int W     = 37,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [W-1:0]     i_dat,
  input  logic             i_pop,
  output logic [W-1:0]     o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic [W-1:0]     o_ent [DEPTH],
  output logic [DEPTH-1:0] o_vld
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_dat;
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);

  // Index 0 is the head (oldest); higher indices are younger.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      o_ent[k] = r_mem[r_rd + PW'(k)];
      o_vld[k] = (CW'(k) < r_cnt);
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue + operand read front end for a 2R1W regfile; WB_FORWARD_EN enables queue forwarding.
// Push-to-write 1 cycle min; readies drop only when full (round-robin on contention), wb_hold freezes drain.
module regfile_wb_queue
  import regfile_wb_queue_pkg::*;
#(
  parameter  int DW     = DW_DEF,
  parameter  int AW     = AW_DEF,
  parameter  int QDEPTH = 4,
  localparam int CW     = $clog2(QDEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_rd,
  input  logic [DW-1:0] ld_data,
  input  logic          wb_hold,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  output logic          rd_stall,
  output logic [CW-1:0] q_count,
  output logic          WE_Reg,
  output logic [AW-1:0] A3,
  output logic [DW-1:0] WD_Reg,
  output logic [AW-1:0] A1,
  output logic [AW-1:0] A2,
  input  logic [DW-1:0] RD1,
  input  logic [DW-1:0] RD2
);

  localparam int EW = AW + DW;

  src_t            r_rr;
  logic            w_full;
  logic            w_empty;
  logic            w_alu_fire;
  logic            w_ld_fire;
  logic            w_push;
  logic            w_pop;
  logic [AW-1:0]   w_push_rd;
  logic [DW-1:0]   w_push_data;
  logic [EW-1:0]   w_head;
  logic [EW-1:0]   w_ent [QDEPTH];
  logic [QDEPTH-1:0] w_vld;

  // A producer is granted whenever the other is idle, or on its round-robin turn.
  assign alu_ready   = (!ld_valid  || (r_rr == SRC_ALU)) && !w_full;
  assign ld_ready    = (!alu_valid || (r_rr == SRC_LD))  && !w_full;
  assign w_alu_fire  = alu_valid && alu_ready;
  assign w_ld_fire   = ld_valid  && ld_ready;
  assign w_push_rd   = w_alu_fire ? alu_rd   : ld_rd;
  assign w_push_data = w_alu_fire ? alu_data : ld_data;
  // Writes to x0 complete the handshake but are dropped.
  assign w_push      = (w_alu_fire || w_ld_fire) && (w_push_rd != '0);
  assign w_pop       = !w_empty && !wb_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_rr <= SRC_ALU;
    else if (alu_valid && ld_valid && !w_full)  r_rr <= src_other(r_rr);
  end

  wb_fifo #(.W(EW), .DEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_dat   ({w_push_rd, w_push_data}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (q_count),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_ent   (w_ent),
    .o_vld   (w_vld)
  );

  assign WE_Reg = w_pop;
  assign A3     = w_pop ? w_head[EW-1 -: AW] : '0;
  assign WD_Reg = w_pop ? w_head[DW-1:0]     : '0;
  assign A1     = rs1_addr;
  assign A2     = rs2_addr;

`ifdef WB_FORWARD_EN
  logic [DW-1:0] w_fwd1;
  logic [DW-1:0] w_fwd2;

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    w_fwd1 = RD1;
    w_fwd2 = RD2;
    for (int k = 0; k < QDEPTH; k++) begin
      if (w_vld[k] && (w_ent[k][EW-1 -: AW] == rs1_addr)) w_fwd1 = w_ent[k][DW-1:0];
      if (w_vld[k] && (w_ent[k][EW-1 -: AW] == rs2_addr)) w_fwd2 = w_ent[k][DW-1:0];
    end
  end

  assign rs1_data = (rs1_addr == '0) ? '0 : w_fwd1;
  assign rs2_data = (rs2_addr == '0) ? '0 : w_fwd2;
  assign rd_stall = 1'b0;
`else
  logic w_hit1;
  logic w_hit2;

  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int k = 0; k < QDEPTH; k++) begin
      if (w_vld[k] && (w_ent[k][EW-1 -: AW] == rs1_addr)) w_hit1 = 1'b1;
      if (w_vld[k] && (w_ent[k][EW-1 -: AW] == rs2_addr)) w_hit2 = 1'b1;
    end
  end

  assign rs1_data = (rs1_addr == '0) ? '0 : RD1;
  assign rs2_data = (rs2_addr == '0) ? '0 : RD2;
  assign rd_stall = ((rs1_addr != '0) && w_hit1) || ((rs2_addr != '0) && w_hit2);
`endif

endmodule
